// File: rtl/poker_round_controller.sv
// Poker round sequencer: deal, process, settle, latch result and keep score.
// Deal and process phases are guarded by a shared timeout counter.
module poker_round_controller #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_job,
  input  logic       clr_scores,
  input  logic       deal_done,
  input  logic       proc_done,
  input  logic       winner,
  input  logic [2:0] card_level_p1,
  input  logic [2:0] card_level_p2,
  output logic       deal_start,
  output logic       busy,
  output logic       result_valid,
  output logic       round_winner,
  output logic [2:0] round_level,
  output logic [7:0] p1_wins,
  output logic [7:0] p2_wins,
  output logic [7:0] round_count,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    IDLE, DEAL, PROCESS, SETTLE, LATCH, ERROR
  } state_t;

  localparam logic [9:0] TO_LIM = 10'(TIMEOUT_CYCLES);
  localparam logic [3:0] ST_LD  = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic       start_q;
  logic [9:0] tcnt;
  logic [3:0] scnt;
  logic [9:0] tnext;
  logic       start_ev;

  assign tnext    = tcnt + 10'd1;
  assign start_ev = start_q & ~start_job;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      tcnt         <= '0;
      scnt         <= '0;
      deal_start   <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      round_winner <= 1'b0;
      round_level  <= '0;
      p1_wins      <= '0;
      p2_wins      <= '0;
      round_count  <= '0;
      timeout_err  <= 1'b0;
    end else begin
      start_q      <= start_job;
      result_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_ev) begin
            state       <= DEAL;
            busy        <= 1'b1;
            deal_start  <= 1'b1;
            tcnt        <= '0;
            timeout_err <= 1'b0;
          end
        end
        DEAL: begin
          tcnt <= tnext;
          // timeout takes priority over a late deal_done
          if (tnext == TO_LIM) begin
            state       <= ERROR;
            deal_start  <= 1'b0;
            timeout_err <= 1'b1;
          end else if (deal_done) begin
            state      <= PROCESS;
            deal_start <= 1'b0;
            tcnt       <= '0;
          end
        end
        PROCESS: begin
          tcnt <= tnext;
          if (tnext == TO_LIM) begin
            state       <= ERROR;
            timeout_err <= 1'b1;
          end else if (proc_done) begin
            state <= SETTLE;
            scnt  <= ST_LD;
          end
        end
        SETTLE: begin
          if (scnt == 4'd0) begin
            state        <= LATCH;
            result_valid <= 1'b1;
            round_winner <= winner;
            round_level  <= winner ? card_level_p2 : card_level_p1;
            round_count  <= sat_inc(round_count);
            if (winner) p2_wins <= sat_inc(p2_wins);
            else        p1_wins <= sat_inc(p1_wins);
          end else begin
            scnt <= scnt - 4'd1;
          end
        end
        LATCH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        ERROR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (clr_scores) begin
        p1_wins     <= '0;
        p2_wins     <= '0;
        round_count <= '0;
      end
    end
  end

endmodule

// File: doc/poker_round_controller.md
POKER_ROUND_CONTROLLER -- requirements
Module: poker_round_controller

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, meaning cycles waited after proc_done before sampling the result (legal range 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1023, meaning the maximum cycles waited in DEAL or PROCESS (legal range 1..1023).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  asynchronous active-low reset.
REQ-005 start_job  in  1  clk-synchronous button level; a release (1->0) requests a round.
REQ-006 clr_scores  in  1  synchronous pulse that clears the score counters.
REQ-007 deal_done  in  1  level from the card generator: deal complete.
REQ-008 proc_done  in  1  level: all nine card processors complete.
REQ-009 winner  in  1  comparator result: 0 = player 1, 1 = player 2.
REQ-010 card_level_p1, card_level_p2  in  3 each  evaluated hand levels.
REQ-011 deal_start  out  1  enables the card generator.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 result_valid  out  1  one-cycle pulse when a result is latched.
REQ-014 round_winner  out  1  latched winner.
REQ-015 round_level  out  3  latched level of the winning player.
REQ-016 p1_wins, p2_wins, round_count  out  8 each  score counters.
REQ-017 timeout_err  out  1  sticky error flag.

Function
REQ-018 SHALL register start_job every cycle; a start event is prev=1 and now=0.
REQ-019 SHALL implement the states IDLE, DEAL, PROCESS, SETTLE, LATCH and ERROR.
REQ-020 In IDLE, a start event SHALL move to DEAL on the next edge and clear timeout_err.
REQ-021 SHALL ignore start events in every state other than IDLE; they are not queued.
REQ-022 In DEAL, deal_start SHALL be 1; deal_done=1 moves to PROCESS and deal_start is 0 from that cycle.
REQ-023 In PROCESS, proc_done=1 SHALL move to SETTLE and load the settle counter with SETTLE_CYCLES-1.
REQ-024 A 10-bit timeout counter SHALL clear on entry to DEAL and to PROCESS, and increment each cycle spent in those states.
REQ-025 When the timeout counter reaches TIMEOUT_CYCLES, the block SHALL go to ERROR; the done input is ignored on that cycle.
REQ-026 In SETTLE, the counter SHALL decrement and move to LATCH when it is 0, giving exactly SETTLE_CYCLES cycles in SETTLE.
REQ-027 Dropping proc_done during SETTLE SHALL have no effect.
REQ-028 LATCH SHALL last one cycle and then go to IDLE.
REQ-029 In LATCH: result_valid=1 for that cycle; round_winner<=winner; round_level<=(winner ? card_level_p2 : card_level_p1).
REQ-030 In LATCH: round_count increments, and p1_wins or p2_wins increments per winner.
REQ-031 All counters SHALL saturate at 255, with no wrap.
REQ-032 ERROR SHALL set timeout_err=1, hold deal_start=0, and go to IDLE after one cycle; timeout_err stays 1 until the next accepted start event or reset.
REQ-033 clr_scores SHALL zero p1_wins, p2_wins and round_count in any state; if it coincides with LATCH, the clear wins (counters read 0), and round_winner and round_level still update.
REQ-034 round_winner and round_level SHALL hold their values until the next LATCH.

Reset
REQ-035 rst=0 SHALL immediately force IDLE with every output and internal register at 0, including mid-round; deal_start drops asynchronously.
REQ-036 After rst returns to 1, a start event is required before any round begins; the start_job sampling register resets to 0, so a held button cannot false-trigger.

Verification
REQ-037 Nominal round: start_job 1->0; deal_done 3 cycles later; proc_done 2 cycles after that; winner=1, card_level_p2=5 -> one result_valid pulse exactly 4 cycles after PROCESS exit, round_winner=1, round_level=5, p2_wins=1, round_count=1.
REQ-038 Deal timeout: start event with deal_done held 0 -> deal_start high for 1023 cycles, ERROR, timeout_err=1, no result_valid, counters unchanged; the next start clears timeout_err.
REQ-039 Saturation: 256 rounds with winner=0 -> p1_wins=255, round_count=255 and stay there; p2_wins=0.
REQ-040 Ignored start and reset: a start event during PROCESS does not trigger a second round; rst=0 during SETTLE -> busy=0, no result_valid, all counters 0.
REQ-041 Clear collision: clr_scores asserted in the LATCH cycle with winner=0 -> p1_wins=0, round_count=0, round_winner=0, result_valid=1.
